// File: rtl/decode_stage.sv
// Decode stage of the 16-bit pipelined CPU: register-port selection, load-use
// hazard detection and the ID/EX pipeline register.
package decode_stage_pkg;
  localparam int unsigned XLEN = 16;
  localparam int unsigned RIDX = 4;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            halt;
    logic [RIDX-1:0] op;
    logic [RIDX-1:0] rd;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
  } id_ex_t;
endpackage

module decode_stage
  import decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_instr,
  input  logic            flush,
  output logic [RIDX-1:0] rf_src1,
  output logic [RIDX-1:0] rf_src2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  output logic            stall,
  output logic            ex_valid,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_halt,
  output logic [RIDX-1:0] ex_op,
  output logic [RIDX-1:0] ex_rd,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_imm
);

  logic [RIDX-1:0] opcode, f_rd, f_rs, f_rt;
  logic [RIDX-1:0] src1, src2;
  logic            hazard;
  id_ex_t          dec, ex_q;

  assign opcode = id_instr[15:12];
  assign f_rd   = id_instr[11:8];
  assign f_rs   = id_instr[7:4];
  assign f_rt   = id_instr[3:0];

  // Opcode decode: source ports, controls and immediate; unused fields stay 0
  always_comb begin
    src1      = '0;
    src2      = '0;
    dec       = '0;
    dec.valid = 1'b1;
    dec.op    = opcode;
    dec.a     = rf_data1;
    dec.b     = rf_data2;
    if (!opcode[3]) begin
      src1         = f_rs;
      src2         = f_rt;
      dec.regwrite = 1'b1;
      dec.rd       = f_rd;
    end else begin
      case (opcode[2:0])
        3'd0: begin
          src1         = f_rs;
          dec.memread  = 1'b1;
          dec.regwrite = 1'b1;
          dec.rd       = f_rd;
          dec.imm      = {{12{id_instr[3]}}, id_instr[3:0]};
        end
        3'd1: begin
          src1         = f_rs;
          src2         = f_rd;
          dec.memwrite = 1'b1;
          dec.imm      = {{12{id_instr[3]}}, id_instr[3:0]};
        end
        3'd2, 3'd3: begin
          src1         = f_rd;
          dec.regwrite = 1'b1;
          dec.rd       = f_rd;
          dec.imm      = {8'h00, id_instr[7:0]};
        end
        3'd4: dec.imm = {{7{id_instr[8]}}, id_instr[8:0]};
        3'd5: src1 = f_rs;
        3'd6: begin
          dec.regwrite = 1'b1;
          dec.rd       = f_rd;
        end
        3'd7: dec.halt = 1'b1;
        default: ;
      endcase
    end
  end

  // Unused ports read as r0, so the nonzero ex_rd test also excludes them
  assign hazard = id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != '0)
                & ((ex_q.rd == src1) | (ex_q.rd == src2));
  assign stall   = hazard & ~flush;
  assign rf_src1 = src1;
  assign rf_src2 = src2;

  // ID/EX register: flush, stall or empty IF/ID all load a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q <= '0;
    end else if (flush || stall || !id_valid) begin
      ex_q <= '0;
    end else begin
      ex_q <= dec;
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_regwrite = ex_q.regwrite;
  assign ex_memread  = ex_q.memread;
  assign ex_memwrite = ex_q.memwrite;
  assign ex_halt     = ex_q.halt;
  assign ex_op       = ex_q.op;
  assign ex_rd       = ex_q.rd;
  assign ex_a        = ex_q.a;
  assign ex_b        = ex_q.b;
  assign ex_imm      = ex_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: decode, immediates, load-use stall,
// flush priority and asynchronous reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [15:0] id_instr;
  logic        flush;
  logic [3:0]  rf_src1, rf_src2;
  logic [15:0] rf_data1, rf_data2;
  logic        stall;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_halt;
  logic [3:0]  ex_op, ex_rd;
  logic [15:0] ex_a, ex_b, ex_imm;

  int tests = 0;
  int fails = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .stall(stall), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_halt(ex_halt),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] instr);
    id_valid = 1'b1;
    id_instr = instr;
    #1;
  endtask

  initial begin
    rst = 1'b0; id_valid = 1'b0; id_instr = '0; flush = 1'b0;
    rf_data1 = '0; rf_data2 = '0;
    #2;
    chk("reset_valid", 16'(ex_valid), 16'h0);
    chk("reset_stall", 16'(stall), 16'h0);
    chk("reset_a", ex_a, 16'h0);
    tick();
    rst = 1'b1;

    // ALU decode
    rf_data1 = 16'h1111; rf_data2 = 16'h2222;
    issue(16'h0123);
    chk("alu_src1", 16'(rf_src1), 16'h2);
    chk("alu_src2", 16'(rf_src2), 16'h3);
    tick();
    chk("alu_valid", 16'(ex_valid), 16'h1);
    chk("alu_op", 16'(ex_op), 16'h0);
    chk("alu_rd", 16'(ex_rd), 16'h1);
    chk("alu_a", ex_a, 16'h1111);
    chk("alu_b", ex_b, 16'h2222);
    chk("alu_regwrite", 16'(ex_regwrite), 16'h1);
    chk("alu_imm", ex_imm, 16'h0);

    // LW immediate
    issue(16'h8A5F);
    chk("lw_src1", 16'(rf_src1), 16'h5);
    chk("lw_src2", 16'(rf_src2), 16'h0);
    tick();
    chk("lw_imm", ex_imm, 16'hFFFF);
    chk("lw_memread", 16'(ex_memread), 16'h1);
    chk("lw_rd", 16'(ex_rd), 16'hA);
    chk("lw_op", 16'(ex_op), 16'h8);

    // LHB immediate, no hazard against LW r10
    issue(16'hB3F0);
    chk("lhb_src1", 16'(rf_src1), 16'h3);
    chk("lhb_stall", 16'(stall), 16'h0);
    tick();
    chk("lhb_imm", ex_imm, 16'h00F0);
    chk("lhb_rd", 16'(ex_rd), 16'h3);
    chk("lhb_memread", 16'(ex_memread), 16'h0);

    // Branch 9-bit sign extension
    issue(16'hC1FF);
    chk("b_src1", 16'(rf_src1), 16'h0);
    tick();
    chk("b_imm", ex_imm, 16'hFFFF);
    chk("b_regwrite", 16'(ex_regwrite), 16'h0);
    chk("b_rd", 16'(ex_rd), 16'h0);

    // SW: store data from rd field
    issue(16'h9A5E);
    chk("sw_src1", 16'(rf_src1), 16'h5);
    chk("sw_src2", 16'(rf_src2), 16'hA);
    tick();
    chk("sw_memwrite", 16'(ex_memwrite), 16'h1);
    chk("sw_imm", ex_imm, 16'hFFFE);
    chk("sw_rd", 16'(ex_rd), 16'h0);

    // Load-use: LW r2 then ADD r4,r2,r5
    issue(16'h8203);
    tick();
    issue(16'h0425);
    chk("lu_stall", 16'(stall), 16'h1);
    tick();
    chk("lu_bubble_valid", 16'(ex_valid), 16'h0);
    chk("lu_bubble_rd", 16'(ex_rd), 16'h0);
    chk("lu_stall_after", 16'(stall), 16'h0);
    rf_data1 = 16'hAAAA; rf_data2 = 16'h5555;
    tick();
    chk("lu_issue_valid", 16'(ex_valid), 16'h1);
    chk("lu_issue_rd", 16'(ex_rd), 16'h4);
    chk("lu_issue_a", ex_a, 16'hAAAA);
    chk("lu_issue_b", ex_b, 16'h5555);

    // LW to r0 never hazards
    issue(16'h8003);
    tick();
    issue(16'h0100);
    chk("r0_stall", 16'(stall), 16'h0);
    tick();
    chk("r0_valid", 16'(ex_valid), 16'h1);
    chk("r0_rd", 16'(ex_rd), 16'h1);

    // LW r2 then an instruction not using r2
    issue(16'h8200);
    tick();
    issue(16'h0134);
    chk("nouse_stall", 16'(stall), 16'h0);
    tick();
    chk("nouse_valid", 16'(ex_valid), 16'h1);

    // Flush beats a pending hazard
    issue(16'h8203);
    tick();
    issue(16'h0425);
    flush = 1'b1;
    #1;
    chk("flush_stall", 16'(stall), 16'h0);
    tick();
    flush = 1'b0;
    chk("flush_bubble", 16'(ex_valid), 16'h0);
    #1;
    chk("flush_next_stall", 16'(stall), 16'h0);
    tick();
    chk("flush_next_rd", 16'(ex_rd), 16'h4);

    // HLT then empty IF/ID: halt is not sticky
    issue(16'hF000);
    tick();
    chk("hlt_halt", 16'(ex_halt), 16'h1);
    id_valid = 1'b0;
    tick();
    chk("idle_valid", 16'(ex_valid), 16'h0);
    chk("idle_halt", 16'(ex_halt), 16'h0);

    // Reset asserted mid-stall clears everything before the next edge
    issue(16'h8203);
    tick();
    issue(16'h0425);
    chk("rs_stall_pre", 16'(stall), 16'h1);
    rst = 1'b0;
    #1;
    chk("rs_stall", 16'(stall), 16'h0);
    chk("rs_memread", 16'(ex_memread), 16'h0);
    chk("rs_rd", 16'(ex_rd), 16'h0);
    chk("rs_imm", ex_imm, 16'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_reset_rd", 16'(ex_rd), 16'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the 16-bit pipelined CPU, located directly upstream of the register file. It decodes the instruction held in the IF/ID register and drives the two register-file read addresses. It captures the returned operands, control signals and the extended immediate into the ID/EX pipeline register. It also detects load-use hazards: on a hazard it stalls the front end and inserts a bubble into ID/EX.

## Interface
Parameters: none (word width fixed at 16, register index fixed at 4 bits).

- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low
- id_valid  in  1  IF/ID holds a real instruction
- id_instr  in  16  instruction: [15:12] opcode, [11:8] rd/rt, [7:4] rs, [3:0] rt/imm
- flush  in  1  branch-taken squash from EX; the next ID/EX load is a bubble
- rf_src1  out  4  register-file read address 1 (combinational)
- rf_src2  out  4  register-file read address 2 (combinational)
- rf_data1  in  16  register-file read data 1; already bypasses a same-cycle writeback
- rf_data2  in  16  register-file read data 2
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_halt  out  1 each  registered ID/EX controls
- ex_op, ex_rd  out  4 each  registered opcode and destination register
- ex_a, ex_b, ex_imm  out  16 each  registered operand A, operand B and immediate

## Operation

**Opcode classes and register-port selection**
- 0000–0111 ALU: rf_src1=[7:4], rf_src2=[3:0], regwrite=1; ex_rd=[11:8].
- 1000 LW: rf_src1=[7:4], rf_src2=0; memread=1, regwrite=1; ex_rd=[11:8]; imm=sext([3:0]).
- 1001 SW: rf_src1=[7:4], rf_src2=[11:8] (store data); memwrite=1; imm=sext([3:0]).
- 1010 LLB, 1011 LHB: rf_src1=[11:8], rf_src2=0; regwrite=1; ex_rd=[11:8]; imm=zext([7:0]).
- 1100 B: no sources (both 0); imm=sext([8:0]).
- 1101 BR: rf_src1=[7:4], rf_src2=0.
- 1110 PCS: no sources; regwrite=1; ex_rd=[11:8].
- 1111 HLT: halt=1; no sources.

**Decode rules**
- Unused source ports drive 0.
- Register 0 is never a hazard source.
- Fields not listed for an opcode are captured as 0 (ex_rd, ex_imm).

**Load-use hazard**
- hazard = id_valid & ex_valid & ex_memread & (ex_rd≠0) & (ex_rd equals a used source of id_instr).
- stall = hazard & ~flush.

**ID/EX update each rising edge, in priority order**
1. flush=1: load a bubble.
2. stall=1: load a bubble; IF/ID is held upstream and re-presents the same instruction next cycle.
3. id_valid=0: load a bubble.
4. Otherwise: load the decoded instruction. ex_a=rf_data1, ex_b=rf_data2.

**Bubble definition**
- ex_valid, ex_regwrite, ex_memread, ex_memwrite and ex_halt are 0.
- Data fields are 0.

**Reset**
- Asynchronous, on rst low: every ex_* output is 0.
- stall is 0 while reset is asserted, because ex_valid=0.
- Reset asserted mid-stall clears the hazard immediately.

## Timing
- Decode to ID/EX has 1 cycle latency: the instruction presented in cycle N appears on ex_* after edge N+1.
- rf_src1/rf_src2/stall are combinational from id_instr and the ID/EX state; there is no registered read address.
- A load-use hazard costs exactly one bubble. In the cycle after the bubble, ex_memread=0, so the held instruction proceeds.
- Back-to-back LW with a dependent LW: one stall, then normal issue.
- flush together with a hazard: flush wins, stall=0 and a single bubble is loaded.
- ex_halt is a plain pipeline bit; it is not sticky in this block.

## Test plan
- Reset: assert rst low mid-stream → all ex_* read 0 and stall=0 asynchronously, before the next edge.
- ALU decode: id_instr=0x0123 with rf_data1=0x1111 and rf_data2=0x2222 → next edge gives ex_op=0, ex_rd=1, ex_a=0x1111, ex_b=0x2222, ex_regwrite=1, ex_valid=1.
- Immediates:
  - LW 0x8A5F → rf_src1=5, ex_imm=0xFFFF, ex_memread=1.
  - LHB 0xB3F0 → rf_src1=3, ex_imm=0x00F0.
  - B 0xC1FF → ex_imm=0xFFFF.
- Load-use: LW 0x8203 then ADD 0x0425 → stall=1 for one cycle, then one bubble (ex_valid=0). ADD issues on the following edge with fresh rf_data.
- R0 and non-hazards:
  - LW to r0 (0x8003) then ADD 0x0100 → no stall.
  - LW r2 then 0x0134 (no use of r2) → no stall.
- Flush priority: hazard present and flush=1 in the same cycle → stall=0, a bubble is loaded, and the next instruction is not stalled.
